// File: rtl/jstk_input_conditioner.sv
// rtl/jstk_input_conditioner.sv - PmodJSTK frame capture, steering, debounce and fire stretcher
`timescale 1ns/1ps
module jstk_input_conditioner #(
    parameter int DEAD_LO         = 400,
    parameter int DEAD_HI         = 624,
    parameter int HYST            = 16,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int FIRE_HOLD       = 4194304,
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        sndRec,
    input  logic [39:0] jstk_data,
    output logic [9:0]  axis_pos,
    output logic        dir_left,
    output logic        dir_right,
    output logic [2:0]  buttons,
    output logic        fire_req,
    output logic        frame_valid,
    output logic [7:0]  frame_count
);

    // Thresholds live in 11 bits so DEAD_LO+HYST never wraps.
    localparam logic [10:0] LEFT_SET  = 11'(DEAD_LO);
    localparam logic [10:0] LEFT_CLR  = 11'(DEAD_LO + HYST);
    localparam logic [10:0] RIGHT_SET = 11'(DEAD_HI);
    localparam logic [10:0] RIGHT_CLR = 11'(DEAD_HI - HYST);
    localparam logic [2:0]  DB_TARGET = 3'(DEBOUNCE_FRAMES);
    localparam int          HOLD_W    = (FIRE_HOLD > 1) ? $clog2(FIRE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FIRE_HOLD - 1);
    localparam logic [3:0]  COOL_LOAD = 4'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {IDLE, HOLD, COOL} fire_state_t;

    logic              sndRec_d;
    logic              capture;
    logic [2:0]        btn_raw;
    logic [10:0]       axis_ext;
    logic [2:0]        agree_cnt [3];
    logic              btn1_prev;
    logic              fire_edge;
    fire_state_t       state;
    fire_state_t       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [3:0]        cool_cnt;
    logic [3:0]        cool_nxt;
    logic              unused_data;

    // Only the axis and button fields of the frame are consumed.
    assign unused_data = ^{jstk_data[39:24], jstk_data[15:10], jstk_data[7:3]};

    assign capture   = sndRec & ~sndRec_d;
    assign axis_ext  = {1'b0, axis_pos};
    assign fire_edge = buttons[1] & ~btn1_prev;
    assign fire_req  = (state == HOLD);

    // Edge-detect the frame strobe and latch the raw frame fields on capture.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            sndRec_d    <= 1'b0;
            axis_pos    <= 10'd512;
            btn_raw     <= 3'b000;
            frame_valid <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            sndRec_d    <= sndRec;
            frame_valid <= capture;
            if (capture) begin
                axis_pos    <= {jstk_data[9:8], jstk_data[23:16]};
                btn_raw     <= jstk_data[2:0];
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Steering with hysteresis, evaluated once per freshly latched frame.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            dir_left  <= 1'b0;
            dir_right <= 1'b0;
        end else if (frame_valid) begin
            if (axis_ext < LEFT_SET) begin
                dir_left <= 1'b1;
            end else if (axis_ext >= LEFT_CLR) begin
                dir_left <= 1'b0;
            end
            if (axis_ext > RIGHT_SET) begin
                dir_right <= 1'b1;
            end else if (axis_ext <= RIGHT_CLR) begin
                dir_right <= 1'b0;
            end
        end
    end

    // Per-button debounce: toggle after DEBOUNCE_FRAMES consecutive disagreeing frames.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            buttons <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                agree_cnt[i] <= 3'd0;
            end
        end else if (frame_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (btn_raw[i] != buttons[i]) begin
                    if (agree_cnt[i] + 3'd1 == DB_TARGET) begin
                        buttons[i]   <= ~buttons[i];
                        agree_cnt[i] <= 3'd0;
                    end else begin
                        agree_cnt[i] <= agree_cnt[i] + 3'd1;
                    end
                end else begin
                    agree_cnt[i] <= 3'd0;
                end
            end
        end
    end

    // Fire FSM state and counter registers; btn1_prev clears on reset so a
    // held button fires again once it re-debounces from 0.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            cool_cnt  <= 4'd0;
            btn1_prev <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            cool_cnt  <= cool_nxt;
            btn1_prev <= buttons[1];
        end
    end

    // Fire FSM next state: edges outside IDLE are dropped, never queued.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        cool_nxt  = cool_cnt;
        case (state)
            IDLE: begin
                if (fire_edge) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    if (COOL_LOAD == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COOL;
                        cool_nxt  = COOL_LOAD;
                    end
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            COOL: begin
                if (cool_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else if (capture) begin
                    cool_nxt = cool_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jstk_input_conditioner.sv
// tb/tb_jstk_input_conditioner.sv - scoreboard bench for jstk_input_conditioner
`timescale 1ns/1ps
module tb_jstk_input_conditioner;

    logic        board_clk;
    logic        reset;
    logic        sndRec;
    logic [39:0] jstk_data;
    logic [9:0]  axis_pos;
    logic        dir_left;
    logic        dir_right;
    logic [2:0]  buttons;
    logic        fire_req;
    logic        frame_valid;
    logic [7:0]  frame_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] axis;
        logic [7:0] count;
        logic       dl;
        logic       dr;
        logic [2:0] btn;
    } frame_rec_t;

    typedef struct {
        longint t;
        longint w;
    } fire_rec_t;

    frame_rec_t frame_q[$];
    fire_rec_t  fire_q[$];
    logic [7:0] exp_count = 8'd0;

    jstk_input_conditioner #(
        .FIRE_HOLD(8),
        .DEBOUNCE_FRAMES(2),
        .COOLDOWN_FRAMES(3)
    ) dut (
        .board_clk(board_clk),
        .reset(reset),
        .sndRec(sndRec),
        .jstk_data(jstk_data),
        .axis_pos(axis_pos),
        .dir_left(dir_left),
        .dir_right(dir_right),
        .buttons(buttons),
        .fire_req(fire_req),
        .frame_valid(frame_valid),
        .frame_count(frame_count)
    );

    initial begin
        board_clk = 1'b0;
        forever #5 board_clk = ~board_clk;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    // One frame: drive data with sndRec high for 'hold' cycles; push the expected
    // response. fire_w>0 means this frame's debounce completes a press that fires.
    task automatic cap(input int a, input logic [2:0] b, input logic edl, input logic edr,
                       input logic [2:0] eb, input int hold, input int fire_w);
        logic [9:0] av;
        frame_rec_t r;
        fire_rec_t  f;
        longint     te;
        av = 10'(a);
        @(negedge board_clk);
        jstk_data = {16'hA5C3, av[7:0], 6'b101101, av[9:8], 5'b10110, b};
        sndRec = 1'b1;
        @(posedge board_clk);
        te = $time;
        exp_count = exp_count + 8'd1;
        r.axis = av; r.count = exp_count; r.dl = edl; r.dr = edr; r.btn = eb;
        frame_q.push_back(r);
        if (fire_w > 0) begin
            f.t = te + 25;
            f.w = fire_w;
            fire_q.push_back(f);
        end
        repeat (hold - 1) @(posedge board_clk);
        @(negedge board_clk);
        sndRec = 1'b0;
    endtask

    // Frame monitor: check latched fields on frame_valid, steering/buttons one cycle later.
    frame_rec_t pend;
    logic       pend_v = 1'b0;
    always @(negedge board_clk) begin
        if (pend_v) begin
            chk("dir_left", dir_left, pend.dl);
            chk("dir_right", dir_right, pend.dr);
            chk("buttons", buttons, pend.btn);
            pend_v = 1'b0;
        end
        if (frame_valid) begin
            if (frame_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_unexpected actual=frame_valid expected=none t=%0t", $time);
            end else begin
                pend = frame_q.pop_front();
                chk("axis_pos", axis_pos, pend.axis);
                chk("frame_count", frame_count, pend.count);
                pend_v = 1'b1;
            end
        end
    end

    // Fire monitor: check start time and pulse width of every fire_req pulse.
    fire_rec_t cur_fire;
    logic      fire_prev   = 1'b0;
    logic      fire_active = 1'b0;
    longint    fire_len    = 0;
    always @(negedge board_clk) begin
        if (fire_req && !fire_prev) begin
            if (fire_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fire_unexpected actual=rise expected=none t=%0t", $time);
                fire_active = 1'b0;
            end else begin
                cur_fire = fire_q.pop_front();
                chk("fire_start", $time, cur_fire.t);
                fire_active = 1'b1;
                fire_len = 1;
            end
        end else if (fire_req && fire_active) begin
            fire_len++;
        end else if (!fire_req && fire_prev && fire_active) begin
            chk("fire_width", fire_len, cur_fire.w);
            fire_active = 1'b0;
        end
        fire_prev = fire_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sndRec = 1'b0;
        jstk_data = 40'd0;
        idle(3);
        reset = 1'b0;
        idle(3);
        chk("rst_axis_pos", axis_pos, 512);
        chk("rst_dir_left", dir_left, 0);
        chk("rst_dir_right", dir_right, 0);
        chk("rst_buttons", buttons, 0);
        chk("rst_fire_req", fire_req, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_count", frame_count, 0);

        // Steering with hysteresis.
        cap(300, 3'b000, 1, 0, 3'b000, 1, 0); idle(2);
        cap(410, 3'b000, 1, 0, 3'b000, 1, 0); idle(2);
        cap(420, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);
        cap(700, 3'b000, 0, 1, 3'b000, 1, 0); idle(2);
        cap(615, 3'b000, 0, 1, 3'b000, 1, 0); idle(2);
        cap(600, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);

        // Edges two cycles apart, then a long strobe giving one capture.
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0);
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b000, 8, 0); idle(2);

        // Buttons 0 and 2 debounce without firing, then release.
        cap(512, 3'b101, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b101, 0, 0, 3'b101, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b101, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);

        // Single-frame glitches on fire button.
        cap(512, 3'b010, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b010, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);

        // Press fires for 8 cycles; release during HOLD.
        cap(512, 3'b010, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b010, 0, 0, 3'b010, 1, 8);
        cap(512, 3'b000, 0, 0, 3'b010, 1, 0);
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0);
        idle(10);

        // Re-press in COOL is discarded; held through COOL end does not fire.
        cap(512, 3'b010, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b010, 0, 0, 3'b010, 1, 0); idle(2);
        cap(512, 3'b010, 0, 0, 3'b010, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b010, 1, 0); idle(2);
        cap(512, 3'b000, 0, 0, 3'b000, 1, 0); idle(2);
        cap(512, 3'b010, 0, 0, 3'b000, 1, 0); idle(2);
        // Re-press after COOL fires; reset 3 cycles into HOLD cuts it short.
        cap(512, 3'b010, 0, 0, 3'b010, 1, 3);
        idle(4);
        reset = 1'b1;
        idle(1);
        chk("reset_fire_req", fire_req, 0);
        chk("reset_buttons", buttons, 0);
        chk("reset_frame_count", frame_count, 0);
        reset = 1'b0;
        exp_count = 8'd0;
        idle(3);

        // 256 captures wrap the frame counter.
        for (int i = 0; i < 256; i++) begin
            cap(512, 3'b000, 0, 0, 3'b000, 1, 0);
            idle(1);
        end
        idle(2);
        chk("wrap_frame_count", frame_count, 0);
        idle(10);
        chk("frame_q_drained", frame_q.size(), 0);
        chk("fire_q_drained", fire_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
